// File: rtl/junction_phase_scheduler_if.sv
// Request/lamp bundle between the intersection sensors/lamp drivers and the phase scheduler.
// master drives sensor and preemption inputs; slave is the scheduler that drives lamps and status.
interface junction_phase_scheduler_if;
  logic [3:0] req;
  logic       emg;
  logic [1:0] emg_dir;
  logic [3:0] red;
  logic [3:0] yel;
  logic [3:0] grn;
  logic [1:0] active;
  logic       busy;
  logic       emg_ack;

  modport master (
    output req, emg, emg_dir,
    input  red, yel, grn, active, busy, emg_ack
  );

  modport slave (
    input  req, emg, emg_dir,
    output red, yel, grn, active, busy, emg_ack
  );
endinterface

// File: rtl/junction_phase_scheduler.sv
// Four-approach round-robin traffic phase scheduler with min/max green, yellow, all-red and emergency preemption.
// Latency: a request latched at edge n is granted at edge n+1 from IDLE; inputs are sampled every cycle (no backpressure).
module junction_phase_scheduler #(
  parameter int GMIN = 4,
  parameter int GMAX = 12,
  parameter int YT   = 2,
  parameter int ART  = 1,
  parameter int TW   = 5
) (
  input logic                       clk,
  input logic                       rst_n,
  junction_phase_scheduler_if.slave bus
);
  typedef enum logic [1:0] {IDLE, GREEN, YELLOW, ALLRED} state_t;

  localparam logic [TW-1:0] T_GMIN = TW'(GMIN - 1);
  localparam logic [TW-1:0] T_GMAX = TW'(GMAX - 1);
  localparam logic [TW-1:0] T_YT   = TW'(YT - 1);
  localparam logic [TW-1:0] T_ART  = TW'(ART - 1);

  state_t        state, state_nx;
  logic [TW-1:0] timer;
  logic [3:0]    pend, pend_nx;
  logic [1:0]    active, active_nx;
  logic [1:0]    sel, idx;
  logic          sel_vld;
  logic [3:0]    act_oh, others, grant_oh, hold_oh;

  assign act_oh = 4'b0001 << active;
  assign others = pend & ~act_oh;

  // Walk active+4 down to active+1 so the nearest pending index after active wins; active itself is last.
  always_comb begin
    sel     = active;
    sel_vld = 1'b0;
    idx     = active;
    for (int k = 4; k >= 1; k--) begin
      idx = active + 2'(k);
      if (pend[idx]) begin
        sel     = idx;
        sel_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    active_nx = active;
    case (state)
      IDLE: begin
        if (bus.emg) begin
          state_nx  = GREEN;
          active_nx = bus.emg_dir;
        end else if (sel_vld) begin
          state_nx  = GREEN;
          active_nx = sel;
        end
      end
      GREEN: begin
        if (bus.emg) begin
          if (bus.emg_dir != active) state_nx = YELLOW;
        end else if ((timer >= T_GMIN) && (|others) &&
                     (!bus.req[active] || (timer >= T_GMAX))) begin
          state_nx = YELLOW;
        end
      end
      YELLOW: begin
        if (timer >= T_YT) state_nx = ALLRED;
      end
      ALLRED: begin
        if (timer >= T_ART) begin
          if (bus.emg) begin
            state_nx  = GREEN;
            active_nx = bus.emg_dir;
          end else if (sel_vld) begin
            state_nx  = GREEN;
            active_nx = sel;
          end else begin
            state_nx  = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // The approach holding green cannot re-latch; the approach being granted has its bit cleared.
  always_comb begin
    grant_oh = 4'b0000;
    if ((state_nx == GREEN) && (state != GREEN)) grant_oh = 4'b0001 << active_nx;
    hold_oh = (state == GREEN) ? act_oh : 4'b0000;
    pend_nx = (pend | (bus.req & ~hold_oh)) & ~grant_oh;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      timer  <= '0;
      pend   <= 4'b0000;
      active <= 2'd3;
    end else begin
      state  <= state_nx;
      active <= active_nx;
      pend   <= pend_nx;
      if (state_nx != state) timer <= '0;
      else if (timer < T_GMAX) timer <= timer + TW'(1);
    end
  end

  always_comb begin
    bus.red = 4'hF;
    bus.yel = 4'h0;
    bus.grn = 4'h0;
    case (state)
      GREEN: begin
        bus.grn = act_oh;
        bus.red = ~act_oh;
      end
      YELLOW: begin
        bus.yel = act_oh;
        bus.red = ~act_oh;
      end
      default: ;
    endcase
  end

  assign bus.active  = active;
  assign bus.busy    = (state != IDLE);
  assign bus.emg_ack = (state == GREEN) && bus.emg && (bus.emg_dir == active);
endmodule
